// File: rtl/video_pkg.sv
// Shared video timing defaults (640x480), scan-out FSM state type and colour-bar palette.
package video_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef enum logic [1:0] {StIdle, StWaitFifo, StRun} vto_state_e;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        rgb = RGB_BLACK;
        unique case (idx)
            3'd0: rgb = RGB_WHITE;
            3'd1: rgb = RGB_YELLOW;
            3'd2: rgb = RGB_CYAN;
            3'd3: rgb = RGB_GREEN;
            3'd4: rgb = RGB_MAGENTA;
            3'd5: rgb = RGB_RED;
            3'd6: rgb = RGB_BLUE;
            3'd7: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters, active-region decode and sync level generation.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cnt_en,
    input  logic          cnt_clr,
    output logic [HW-1:0] h_cnt,
    output logic          active,
    output logic          hsync_lvl,
    output logic          vsync_lvl,
    output logic          frame_first,
    output logic          frame_last
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else if (cnt_clr) begin
            h_q <= '0;
            v_q <= '0;
        end else if (cnt_en) begin
            if (h_q == H_LAST) begin
                h_q <= '0;
                v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    always_comb begin
        h_cnt       = h_q;
        active      = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        hsync_lvl   = (h_q >= HS_START && h_q < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_lvl   = (v_q >= VS_START && v_q < VS_END) ? SYNC_POL : ~SYNC_POL;
        frame_first = (h_q == '0) && (v_q == '0);
        frame_last  = (h_q == H_LAST) && (v_q == V_LAST);
    end

endmodule

// File: rtl/video_timing_out.sv
// Scan-out FSM, show-ahead FIFO handshake and registered video outputs.
// Optional colour-bar generator enabled by VIDEO_TIMING_OUT_TEST_PATTERN_EN.
module video_timing_out
    import video_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter bit          SYNC_POL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [23:0]           pixel,
    output logic                  frame_start,
    output logic                  underflow,
`ifdef VIDEO_TIMING_OUT_TEST_PATTERN_EN
    input  logic                  test_pattern,
`endif
    input  logic                  underflow_clr
);
    localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);

    vto_state_e    state_q, state_d;
    logic [HW-1:0] h_cnt;
    logic          active, hsync_lvl, vsync_lvl, frame_first, frame_last;
    logic          pattern_on, in_active_run, uflow_evt;
    logic [23:0]   pixel_d, pattern_px;
    logic          de_q, frame_start_q, underflow_q, underflow_d, hsync_q, vsync_q;
    logic [23:0]   pixel_q;
    logic          unused_data_msb;

    assign unused_data_msb = ^fifo_rd_data[DATA_WIDTH-1:24];

`ifdef VIDEO_TIMING_OUT_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    assign pattern_on = test_pattern;
    assign pattern_px = bar_rgb(3'(h_cnt / HW'(BAR_W)));
`else
    logic unused_h_cnt;
    assign unused_h_cnt = ^h_cnt;
    assign pattern_on   = 1'b0;
    assign pattern_px   = RGB_BLACK;
`endif

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .HW       (HW)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .cnt_en      (state_q != StIdle),
        .cnt_clr     (state_d == StIdle),
        .h_cnt       (h_cnt),
        .active      (active),
        .hsync_lvl   (hsync_lvl),
        .vsync_lvl   (vsync_lvl),
        .frame_first (frame_first),
        .frame_last  (frame_last)
    );

    // RUN is entered on the last pixel so the first RUN cycle sits at (0,0).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (enable) state_d = StWaitFifo;
            StWaitFifo: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (frame_last && (!fifo_rd_empty || pattern_on)) begin
                    state_d = StRun;
                end
            end
            StRun:      if (frame_last && !enable) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        in_active_run = (state_q == StRun) && active;
        fifo_rd_en    = in_active_run && !fifo_rd_empty && !pattern_on;
        uflow_evt     = in_active_run && fifo_rd_empty && !pattern_on;
        pixel_d       = 24'h0;
        if (in_active_run && pattern_on) begin
            pixel_d = pattern_px;
        end else if (fifo_rd_en) begin
            pixel_d = fifo_rd_data[23:0];
        end
        // A fresh underflow wins over a simultaneous clear.
        underflow_d = underflow_q;
        if (underflow_clr) underflow_d = 1'b0;
        if (uflow_evt)     underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            de_q          <= 1'b0;
            pixel_q       <= 24'h0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
        end else begin
            state_q       <= state_d;
            de_q          <= in_active_run;
            pixel_q       <= pixel_d;
            frame_start_q <= (state_q == StRun) && frame_first;
            underflow_q   <= underflow_d;
            hsync_q       <= hsync_lvl;
            vsync_q       <= vsync_lvl;
        end
    end

    assign de          = de_q;
    assign pixel       = pixel_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;

endmodule

// File: tb/tb_video_timing_out.sv
// Directed bench for video_timing_out on a reduced 24x10 raster with a show-ahead FIFO model.
module tb_video_timing_out;
    localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_empty;
    logic        hsync, vsync, de, frame_start, underflow;
    logic [23:0] pixel;
    logic        underflow_clr = 1'b0;
`ifdef VIDEO_TIMING_OUT_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif

    int unsigned pop_cnt = 0;
    int unsigned load = 0;
    logic        force_empty = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign fifo_rd_empty = (pop_cnt >= load) || force_empty;
    assign fifo_rd_data  = 32'h00A0_0000 + pop_cnt;

    always @(posedge clk) if (fifo_rd_en) pop_cnt <= pop_cnt + 1;

    video_timing_out #(
        .DATA_WIDTH (32),
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .hsync         (hsync),
        .vsync         (vsync),
        .de            (de),
        .pixel         (pixel),
        .frame_start   (frame_start),
        .underflow     (underflow),
`ifdef VIDEO_TIMING_OUT_TEST_PATTERN_EN
        .test_pattern  (test_pattern),
`endif
        .underflow_clr (underflow_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_fs(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit          found;
        int          err, blk, des, fs_seen;
        int unsigned base, exp_pix, hh, vv;
        logic [23:0] bars [8];

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_de", de, 0);
        check("rst_pixel", pixel, 0);
        check("rst_fs", frame_start, 0);
        check("rst_uflow", underflow, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);

        // Frame 1: full FIFO, raster timing and pixel order
        load = 3 * HA * VA;
        enable = 1'b1;
        rst = 1'b0;
        wait_fs(3 * FRAME, found);
        check("f1_start_seen", found, 1);
        check("f1_first_de", de, 1);
        check("f1_first_pix", pixel, 24'hA00000);
        err = 0;
        exp_pix = 32'h00A0_0000;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            hh = k % HT;
            vv = k / HT;
            if (hsync !== !(hh >= HA + HF && hh < HA + HF + HS)) err++;
            if (vsync !== !(vv >= VA + VF && vv < VA + VF + VS)) err++;
            if (de !== (hh < HA && vv < VA)) err++;
            if (frame_start !== (k == 0)) err++;
            if (de) begin
                if (32'(pixel) !== exp_pix) err++;
                exp_pix++;
            end
        end
        check("f1_timing_errs", err, 0);
        check("f1_pops", pop_cnt, HA * VA);
        check("f1_uflow", underflow, 0);
        base = pop_cnt;

        // Frame 2: ten empty cycles mid-line 5, clear coinciding with the first event
        blk = 0;
        des = 0;
        for (int s = 0; s < FRAME; s++) begin
            @(negedge clk);
            if (s == 0) check("f2_period", frame_start, 1);
            if (de) des++;
            if (de && pixel == 24'h0) blk++;
            if (s == 122) begin
                check("f2_uflow_before", underflow, 0);
                force_empty = 1'b1;
                underflow_clr = 1'b1;
            end
            if (s == 123) begin
                check("f2_clr_vs_set", underflow, 1);
                underflow_clr = 1'b0;
            end
            if (s == 132) force_empty = 1'b0;
        end
        check("f2_black", blk, 10);
        check("f2_de_count", des, HA * VA);
        check("f2_pops", pop_cnt - base, HA * VA - 10);
        check("f2_uflow_sticky", underflow, 1);
        underflow_clr = 1'b1;
        base = pop_cnt;

        // Frame 3: enable dropped on line 2 still completes the frame
        des = 0;
        for (int s = 0; s < FRAME; s++) begin
            @(negedge clk);
            if (s == 0) begin
                check("f3_uflow_cleared", underflow, 0);
                check("f3_start", frame_start, 1);
                underflow_clr = 1'b0;
            end
            if (s == 2 * HT - 1) enable = 1'b0;
            if (de) des++;
        end
        check("f3_de_count", des, HA * VA);
        check("f3_pops", pop_cnt - base, HA * VA);
        base = pop_cnt;
        err = 0;
        for (int s = 0; s < 300; s++) begin
            @(negedge clk);
            if (de || frame_start || fifo_rd_en || !hsync || !vsync) err++;
        end
        check("idle_quiet", err, 0);
        check("idle_no_pops", pop_cnt - base, 0);

        // Reset mid-line, then re-entry gated by a nonempty FIFO
        enable = 1'b1;
        wait_fs(3 * FRAME, found);
        check("d_start_seen", found, 1);
        repeat (30) @(negedge clk);
        check("d_de_before_rst", de, 1);
        rst = 1'b1;
        #1;
        check("d_rst_de", de, 0);
        check("d_rst_pixel", pixel, 0);
        check("d_rst_rd_en", fifo_rd_en, 0);
        check("d_rst_hsync", hsync, 1);
        @(negedge clk);
        load = pop_cnt;
        base = pop_cnt;
        @(negedge clk);
        rst = 1'b0;
        fs_seen = 0;
        for (int s = 0; s < 2 * FRAME + 50; s++) begin
            @(negedge clk);
            if (frame_start) fs_seen++;
        end
        check("d_empty_no_start", fs_seen, 0);
        check("d_empty_no_pops", pop_cnt - base, 0);
        load = pop_cnt + 200;
        wait_fs(FRAME + 10, found);
        check("d_restart_seen", found, 1);
        repeat (HA + HF - 1) @(negedge clk);
        check("d_hsync_h17", hsync, 1);
        @(negedge clk);
        check("d_hsync_h18", hsync, 0);

`ifdef VIDEO_TIMING_OUT_TEST_PATTERN_EN
        // Colour bars with an empty FIFO
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        rst = 1'b1;
        @(negedge clk);
        load = pop_cnt;
        base = pop_cnt;
        test_pattern = 1'b1;
        rst = 1'b0;
        wait_fs(3 * FRAME, found);
        check("tp_start_seen", found, 1);
        check("tp_bar0", pixel, 24'hFFFFFF);
        err = 0;
        for (int k = 0; k < HA; k++) begin
            if (k > 0) @(negedge clk);
            if (!de || pixel !== bars[k / (HA / 8)]) err++;
            if (k == HA - 2) check("tp_bar7", pixel, 24'h000000);
        end
        check("tp_bar_errs", err, 0);
        check("tp_no_pops", pop_cnt - base, 0);
        check("tp_no_uflow", underflow, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
